// File: rtl/pipeline_controller.sv
// Purpose: run/step/halt sequencing, load-use stall and decode-branch flush control for the 5-stage pipeline.
// Latency: state is registered (commands take effect on the next edge); all enables are combinational from state and hazard inputs.
// Backpressure: none accepted; o_pipe_enable=0 freezes every pipeline register, load-use holds PC and IF/ID for one cycle.
// Optional: define STALL_COUNTER_EN to add o_stall_count (saturating count of load-use stall cycles).
module pipeline_controller #(
    parameter int NB_REG   = 5,
    parameter int NB_COUNT = 32
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_run,
    input  logic                i_step,
    input  logic                i_clear,
    input  logic                i_halt_wb,
    input  logic                i_idex_mem_read,
    input  logic [NB_REG-1:0]   i_idex_rt,
    input  logic [NB_REG-1:0]   i_ifid_rs,
    input  logic [NB_REG-1:0]   i_ifid_rt,
    input  logic                i_ifid_uses_rt,
    input  logic                i_branch_taken,
    output logic                o_pipe_enable,
    output logic                o_pc_write,
    output logic                o_ifid_write,
    output logic                o_ifid_flush,
    output logic                o_idex_bubble,
    output logic [1:0]          o_state,
`ifdef STALL_COUNTER_EN
    output logic [NB_COUNT-1:0] o_stall_count,
`endif
    output logic [NB_COUNT-1:0] o_cycle_count
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        STEP = 2'b10,
        DONE = 2'b11
    } state_t;

    localparam logic [NB_COUNT-1:0] COUNT_MAX = '1;

    state_t state;
    state_t state_nxt;
    logic   load_use;

    // State register; reset always lands in IDLE so a step can never be left half-done.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: run beats step from IDLE, a step is always exactly one enabled cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (i_run) begin
                    state_nxt = RUN;
                end else if (i_step) begin
                    state_nxt = STEP;
                end
            end
            RUN: begin
                if (i_halt_wb) begin
                    state_nxt = DONE;
                end
            end
            STEP: begin
                state_nxt = i_halt_wb ? DONE : IDLE;
            end
            DONE: begin
                if (i_clear) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Enable and hazard outputs; a stall overrides a taken branch because ID operands are stale.
    always_comb begin
        o_pipe_enable = (state == RUN) || (state == STEP);
        load_use      = i_idex_mem_read && (i_idex_rt != '0) &&
                        ((i_idex_rt == i_ifid_rs) ||
                         (i_ifid_uses_rt && (i_idex_rt == i_ifid_rt)));
        o_pc_write    = 1'b0;
        o_ifid_write  = 1'b0;
        o_ifid_flush  = 1'b0;
        o_idex_bubble = 1'b0;
        if (o_pipe_enable) begin
            o_pc_write    = ~load_use;
            o_ifid_write  = ~load_use;
            o_idex_bubble = load_use;
            o_ifid_flush  = i_branch_taken & ~load_use;
        end
    end

    assign o_state = state;

    // Enabled-cycle counter, saturating; i_clear leaves it alone so the debugger can read it after DONE.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_cycle_count <= '0;
        end else if (o_pipe_enable && (o_cycle_count != COUNT_MAX)) begin
            o_cycle_count <= o_cycle_count + 1'b1;
        end
    end

`ifdef STALL_COUNTER_EN
    // Load-use stall counter, saturating.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_stall_count <= '0;
        end else if (o_pipe_enable && load_use && (o_stall_count != COUNT_MAX)) begin
            o_stall_count <= o_stall_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench for pipeline_controller: run/step/halt FSM, load-use stall, branch flush, counters.
// A second instance with a 3-bit counter shares all inputs to exercise counter saturation.
`timescale 1ns/1ps
module tb_pipeline_controller;

    logic       i_clk = 1'b0;
    logic       i_reset, i_run, i_step, i_clear, i_halt_wb;
    logic       i_idex_mem_read, i_ifid_uses_rt, i_branch_taken;
    logic [4:0] i_idex_rt, i_ifid_rs, i_ifid_rt;
    logic       o_pipe_enable, o_pc_write, o_ifid_write, o_ifid_flush, o_idex_bubble;
    logic [1:0] o_state;
    logic [31:0] o_cycle_count;
    logic       s_pipe_enable, s_pc_write, s_ifid_write, s_ifid_flush, s_idex_bubble;
    logic [1:0] s_state;
    logic [2:0] s_cycle_count;
`ifdef STALL_COUNTER_EN
    logic [31:0] o_stall_count;
    logic [2:0]  s_stall_count;
`endif

    int vectors = 0;
    int errors  = 0;

    always #5 i_clk = ~i_clk;

    pipeline_controller #(.NB_REG(5), .NB_COUNT(32)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_run(i_run), .i_step(i_step), .i_clear(i_clear),
        .i_halt_wb(i_halt_wb), .i_idex_mem_read(i_idex_mem_read), .i_idex_rt(i_idex_rt),
        .i_ifid_rs(i_ifid_rs), .i_ifid_rt(i_ifid_rt), .i_ifid_uses_rt(i_ifid_uses_rt),
        .i_branch_taken(i_branch_taken), .o_pipe_enable(o_pipe_enable), .o_pc_write(o_pc_write),
        .o_ifid_write(o_ifid_write), .o_ifid_flush(o_ifid_flush), .o_idex_bubble(o_idex_bubble),
        .o_state(o_state),
`ifdef STALL_COUNTER_EN
        .o_stall_count(o_stall_count),
`endif
        .o_cycle_count(o_cycle_count)
    );

    pipeline_controller #(.NB_REG(5), .NB_COUNT(3)) dut_small (
        .i_clk(i_clk), .i_reset(i_reset), .i_run(i_run), .i_step(i_step), .i_clear(i_clear),
        .i_halt_wb(i_halt_wb), .i_idex_mem_read(i_idex_mem_read), .i_idex_rt(i_idex_rt),
        .i_ifid_rs(i_ifid_rs), .i_ifid_rt(i_ifid_rt), .i_ifid_uses_rt(i_ifid_uses_rt),
        .i_branch_taken(i_branch_taken), .o_pipe_enable(s_pipe_enable), .o_pc_write(s_pc_write),
        .o_ifid_write(s_ifid_write), .o_ifid_flush(s_ifid_flush), .o_idex_bubble(s_idex_bubble),
        .o_state(s_state),
`ifdef STALL_COUNTER_EN
        .o_stall_count(s_stall_count),
`endif
        .o_cycle_count(s_cycle_count)
    );

    // Advance one edge; inputs change and outputs are read 1ns after it.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clear_hazard();
        i_idex_mem_read = 1'b0; i_idex_rt = 5'd0; i_ifid_rs = 5'd0;
        i_ifid_rt = 5'd0; i_ifid_uses_rt = 1'b0; i_branch_taken = 1'b0;
    endtask

    // Packs {pipe_enable, pc_write, ifid_write, ifid_flush, idex_bubble}.
    function automatic logic [4:0] ctl();
        return {o_pipe_enable, o_pc_write, o_ifid_write, o_ifid_flush, o_idex_bubble};
    endfunction

    task automatic test_reset();
        i_reset = 1'b1; i_run = 1'b0; i_step = 1'b0; i_clear = 1'b0; i_halt_wb = 1'b0;
        clear_hazard();
        tick(); tick();
        i_reset = 1'b0;
        #1;
        vectors++; if (o_state !== 2'b00) begin errors++; $display("FAIL reset_state got %b expected 00", o_state); end
        vectors++; if (ctl() !== 5'b00000) begin errors++; $display("FAIL reset_ctl got %b expected 00000", ctl()); end
        vectors++; if (o_cycle_count !== 32'd0) begin errors++; $display("FAIL reset_count got %0d expected 0", o_cycle_count); end
        // Hazard inputs while IDLE must not leak through.
        i_idex_mem_read = 1'b1; i_idex_rt = 5'd4; i_ifid_rs = 5'd4; i_branch_taken = 1'b1;
        #1;
        vectors++; if (ctl() !== 5'b00000) begin errors++; $display("FAIL idle_gated got %b expected 00000", ctl()); end
        clear_hazard();
        tick();
        vectors++; if (o_cycle_count !== 32'd0) begin errors++; $display("FAIL idle_no_count got %0d expected 0", o_cycle_count); end
    endtask

    task automatic test_run();
        i_run = 1'b1; tick(); i_run = 1'b0;
        vectors++; if (o_state !== 2'b01) begin errors++; $display("FAIL run_state got %b expected 01", o_state); end
        vectors++; if (ctl() !== 5'b11100) begin errors++; $display("FAIL run_ctl got %b expected 11100", ctl()); end
        vectors++; if (o_cycle_count !== 32'd0) begin errors++; $display("FAIL run_count0 got %0d expected 0", o_cycle_count); end
        for (int i = 0; i < 5; i++) tick();
        vectors++; if (o_cycle_count !== 32'd5) begin errors++; $display("FAIL run_count5 got %0d expected 5", o_cycle_count); end
    endtask

    task automatic test_load_use();
        i_idex_mem_read = 1'b1; i_idex_rt = 5'd8; i_ifid_rs = 5'd8; #1;
        vectors++; if (ctl() !== 5'b10001) begin errors++; $display("FAIL lu_rs got %b expected 10001", ctl()); end
        i_idex_rt = 5'd0; i_ifid_rs = 5'd0; #1;
        vectors++; if (ctl() !== 5'b11100) begin errors++; $display("FAIL lu_r0 got %b expected 11100", ctl()); end
        i_idex_rt = 5'd6; i_ifid_rs = 5'd2; i_ifid_rt = 5'd6; i_ifid_uses_rt = 1'b0; #1;
        vectors++; if (ctl() !== 5'b11100) begin errors++; $display("FAIL lu_rt_unused got %b expected 11100", ctl()); end
        i_ifid_uses_rt = 1'b1; #1;
        vectors++; if (ctl() !== 5'b10001) begin errors++; $display("FAIL lu_rt_used got %b expected 10001", ctl()); end
        i_idex_mem_read = 1'b0; #1;
        vectors++; if (ctl() !== 5'b11100) begin errors++; $display("FAIL lu_not_load got %b expected 11100", ctl()); end
        clear_hazard();
    endtask

    task automatic test_branch();
        i_branch_taken = 1'b1; i_ifid_rs = 5'd3; #1;
        vectors++; if (ctl() !== 5'b11110) begin errors++; $display("FAIL br_flush got %b expected 11110", ctl()); end
        i_idex_mem_read = 1'b1; i_idex_rt = 5'd9; i_ifid_uses_rt = 1'b1; i_ifid_rt = 5'd9; #1;
        vectors++; if (ctl() !== 5'b10001) begin errors++; $display("FAIL br_stall_wins got %b expected 10001", ctl()); end
        clear_hazard();
        #1;
    endtask

    task automatic test_halt();
        i_halt_wb = 1'b1; #1;
        vectors++; if (ctl() !== 5'b11100) begin errors++; $display("FAIL halt_cycle got %b expected 11100", ctl()); end
        tick(); i_halt_wb = 1'b0;
        vectors++; if (o_state !== 2'b11) begin errors++; $display("FAIL halt_done got %b expected 11", o_state); end
        vectors++; if (o_cycle_count !== 32'd6) begin errors++; $display("FAIL halt_count got %0d expected 6", o_cycle_count); end
        i_branch_taken = 1'b1; i_idex_mem_read = 1'b1; i_idex_rt = 5'd1; i_ifid_rs = 5'd1; #1;
        vectors++; if (ctl() !== 5'b00000) begin errors++; $display("FAIL done_gated got %b expected 00000", ctl()); end
        clear_hazard();
        i_step = 1'b1; i_run = 1'b1; tick(); i_step = 1'b0; i_run = 1'b0;
        vectors++; if (o_state !== 2'b11) begin errors++; $display("FAIL done_ignores got %b expected 11", o_state); end
        i_clear = 1'b1; tick(); i_clear = 1'b0;
        vectors++; if (o_state !== 2'b00) begin errors++; $display("FAIL clear_idle got %b expected 00", o_state); end
        vectors++; if (o_cycle_count !== 32'd6) begin errors++; $display("FAIL clear_keeps_count got %0d expected 6", o_cycle_count); end
    endtask

    task automatic test_step();
        i_step = 1'b1; tick(); i_step = 1'b0;
        vectors++; if (o_state !== 2'b10 || o_pipe_enable !== 1'b1) begin errors++; $display("FAIL step_enter got state %b en %b expected 10 1", o_state, o_pipe_enable); end
        tick();
        vectors++; if (o_state !== 2'b00 || o_pipe_enable !== 1'b0) begin errors++; $display("FAIL step_exit got state %b en %b expected 00 0", o_state, o_pipe_enable); end
        vectors++; if (o_cycle_count !== 32'd7) begin errors++; $display("FAIL step_count got %0d expected 7", o_cycle_count); end
        vectors++; if (s_cycle_count !== 3'd7) begin errors++; $display("FAIL small_count got %0d expected 7", s_cycle_count); end
        // Step that retires HALT goes straight to DONE.
        i_step = 1'b1; tick(); i_step = 1'b0; i_halt_wb = 1'b1; tick(); i_halt_wb = 1'b0;
        vectors++; if (o_state !== 2'b11) begin errors++; $display("FAIL step_halt got %b expected 11", o_state); end
        i_clear = 1'b1; tick(); i_clear = 1'b0;
        i_run = 1'b1; i_step = 1'b1; tick(); i_run = 1'b0; i_step = 1'b0;
        vectors++; if (o_state !== 2'b01) begin errors++; $display("FAIL run_prio got %b expected 01", o_state); end
        i_clear = 1'b1; i_step = 1'b1; tick(); i_clear = 1'b0; i_step = 1'b0;
        vectors++; if (o_state !== 2'b01) begin errors++; $display("FAIL run_ignores got %b expected 01", o_state); end
        vectors++; if (o_cycle_count !== 32'd9) begin errors++; $display("FAIL run_count9 got %0d expected 9", o_cycle_count); end
        vectors++; if (s_cycle_count !== 3'd7) begin errors++; $display("FAIL small_saturate got %0d expected 7", s_cycle_count); end
    endtask

    task automatic test_reset_mid_run();
        i_reset = 1'b1; tick(); i_reset = 1'b0;
        vectors++; if (o_state !== 2'b00) begin errors++; $display("FAIL rst_mid_state got %b expected 00", o_state); end
        vectors++; if (ctl() !== 5'b00000) begin errors++; $display("FAIL rst_mid_ctl got %b expected 00000", ctl()); end
        vectors++; if (o_cycle_count !== 32'd0) begin errors++; $display("FAIL rst_mid_count got %0d expected 0", o_cycle_count); end
`ifdef STALL_COUNTER_EN
        vectors++; if (o_stall_count !== 32'd0) begin errors++; $display("FAIL stall_reset got %0d expected 0", o_stall_count); end
        i_run = 1'b1; tick(); i_run = 1'b0;
        i_idex_mem_read = 1'b1; i_idex_rt = 5'd5; i_ifid_rs = 5'd5;
        for (int i = 0; i < 3; i++) tick();
        clear_hazard();
        tick();
        vectors++; if (o_stall_count !== 32'd3) begin errors++; $display("FAIL stall_count got %0d expected 3", o_stall_count); end
`endif
    endtask

    initial begin
        test_reset();
        test_run();
        test_load_use();
        test_branch();
        test_halt();
        test_step();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_controller.md
Name: pipeline_controller

Overview:
- Central sequencing block for the 5-stage MIPS pipeline.
- Gates global pipeline advance from a debug run/step/halt FSM.
- Detects load-use hazards, which the EX forwarding muxes cannot cover, and inserts one bubble into ID/EX.
- Flushes IF/ID on branches and jumps taken in decode; keeps a cycle counter readable by the debug unit.

Parameters:
NB_REG, 5, register-address width
NB_COUNT, 32, width of cycle counter (and stall counter when enabled)

Ports:
i_clk  in  1  clock
i_reset  in  1  reset
i_run  in  1  pulse: start continuous execution
i_step  in  1  pulse: advance exactly one cycle
i_clear  in  1  pulse: leave DONE, return to IDLE
i_halt_wb  in  1  HALT instruction is in WB this cycle
i_idex_mem_read  in  1  instruction in ID/EX is a load
i_idex_rt  in  NB_REG  load destination (rt) in ID/EX
i_ifid_rs  in  NB_REG  rs of instruction in IF/ID
i_ifid_rt  in  NB_REG  rt of instruction in IF/ID
i_ifid_uses_rt  in  1  IF/ID instruction reads rt (R-type, store, branch)
i_branch_taken  in  1  branch/jump resolved taken in decode
o_pipe_enable  out  1  global advance enable for all pipeline registers
o_pc_write  out  1  PC update enable
o_ifid_write  out  1  IF/ID load enable
o_ifid_flush  out  1  IF/ID clear (inject NOP)
o_idex_bubble  out  1  zero all ID/EX control signals
o_state  out  2  FSM state: 00 IDLE, 01 RUN, 10 STEP, 11 DONE
o_cycle_count  out  NB_COUNT  enabled-cycle count

Behaviour:
Interface:
- Reset i_reset, synchronous, active-high; clock i_clk.
- Reset puts the FSM in IDLE and clears the counters to 0.
- Out of reset, all control outputs are 0: o_pipe_enable, o_pc_write, o_ifid_write, o_ifid_flush, o_idex_bubble.

FSM (registered state):
- IDLE:
  - i_run -> RUN.
  - else i_step -> STEP.
  - i_run has priority if asserted together with i_step.
- RUN:
  - i_halt_wb -> DONE.
  - i_run, i_step and i_clear are ignored.
- STEP:
  - Exactly one enabled cycle.
  - Next state is DONE if i_halt_wb, else IDLE.
- DONE:
  - Pipeline frozen.
  - i_clear -> IDLE.
  - i_run and i_step are ignored.
- Reset asserted mid-RUN or mid-STEP returns to IDLE on the next edge. No partial step.

Enable (combinational from state):
- o_pipe_enable = 1 in RUN and STEP, else 0.
- The HALT cycle itself (RUN with i_halt_wb=1) is still enabled, so WB of the HALT instruction completes.

Hazard logic (combinational, qualified by o_pipe_enable):
- load_use = i_idex_mem_read & (i_idex_rt != 0) & ((i_idex_rt == i_ifid_rs) | (i_ifid_uses_rt & i_idex_rt == i_ifid_rt)).
- On load_use: o_pc_write=0, o_ifid_write=0, o_idex_bubble=1, o_ifid_flush=0.
- With no hazard: o_pc_write=o_ifid_write=1 and o_idex_bubble=0.
- Exactly one bubble per load-use; the next cycle's forwarding covers the rest.
- Branch: o_ifid_flush = i_branch_taken & ~load_use.
  - Stall wins over branch because the operands in ID are stale.
  - The branch re-resolves next cycle.
- When o_pipe_enable=0, all of o_pc_write, o_ifid_write, o_ifid_flush and o_idex_bubble are 0.

Counter:
- o_cycle_count increments on every cycle with o_pipe_enable=1.
- Saturates at all-ones, with no wrap.
- Cleared only by reset; i_clear does not clear it.

Optional Feature:
- Macro STALL_COUNTER_EN.
- Defined: adds output o_stall_count [NB_COUNT].
  - Increments on each cycle where o_pipe_enable & load_use.
  - Saturates; reset to 0.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
1. Reset, then i_run pulse → o_state goes 00→01 next edge. o_pipe_enable=1. o_cycle_count reads 5 after 5 enabled cycles.
2. RUN with i_idex_mem_read=1, i_idex_rt=8, i_ifid_rs=8 → o_pc_write=0, o_ifid_write=0, o_idex_bubble=1 for that cycle. With i_idex_rt=0, no stall.
3. RUN with i_branch_taken=1 and no hazard → o_ifid_flush=1. Same stimulus plus load_use (rt=9, uses_rt=1, ifid_rt=9) → o_ifid_flush=0, o_idex_bubble=1.
4. IDLE with i_step pulse → exactly one cycle of o_pipe_enable=1, then o_state=00. o_cycle_count increments by 1. i_run and i_step together → RUN.
5. RUN with i_halt_wb=1 → o_pipe_enable=1 that cycle, then DONE (11) with all enables 0. i_step is ignored; i_clear → IDLE. Counter is unchanged by i_clear.
6. RUN, then reset asserted for 1 cycle → IDLE, all outputs 0, counter 0. With STALL_COUNTER_EN defined: 3 load-use cycles → o_stall_count=3.
